// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: valid/ready load port, stallable
// serial output, MSB- or LSB-first, gapless back-to-back frames.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   i_load_valid      upstream word present on i_load_data
//   i_load_data       WIDTH-bit parallel word
//   o_load_ready      word can be accepted this cycle (combinational)
//   i_shift_en        downstream consumes the presented bit
//   o_serial_out      presented bit (0 when idle)
//   o_serial_valid    o_serial_out carries a frame bit
//   o_serial_last     presented bit is the final bit of the frame
//   o_bit_index       index of the presented bit, 0 = first sent
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_load_ready,
  input  logic             i_shift_en,
  output logic             o_serial_out,
  output logic             o_serial_valid,
  output logic             o_serial_last,
  output logic [CW-1:0]    o_bit_index
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_busy;
  logic             w_last;
  logic             w_head;

  assign w_busy = (r_state == S_SHIFT);
  assign w_last = w_busy && (r_cnt == LAST);

  // Presented bit sits at the end the shift drains from.
  assign w_head = LSB_FIRST ? r_shift[0]
                            : r_shift[WIDTH-1];

  assign w_shifted = LSB_FIRST
    ? {1'b0, r_shift[WIDTH-1:1]}
    : {r_shift[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_cnt_nxt    = r_cnt;
    o_load_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_load_ready = 1'b1;
        if (i_load_valid) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = i_load_data;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (i_shift_en) begin
          if (!w_last) begin
            w_shift_nxt = w_shifted;
            w_cnt_nxt   = r_cnt + 1'b1;
          end else begin
            // Final-bit consume: the slot is free
            // for a gapless reload this same edge.
            o_load_ready = 1'b1;
            w_cnt_nxt    = '0;
            if (i_load_valid) begin
              w_shift_nxt = i_load_data;
            end else begin
              w_state_nxt = S_IDLE;
              w_shift_nxt = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_serial_valid = w_busy;
  assign o_serial_last  = w_last;
  assign o_serial_out   = w_busy & w_head;
  assign o_bit_index    = w_busy ? r_cnt : '0;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations (8 MSB, 8 LSB, 16 MSB)
// against a word/position model plus literal bit sequences.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  lv, se;
  logic [7:0]  ld0, ld1;
  logic [15:0] ld2;
  logic [2:0]  so, sv, sl, lr;
  logic [2:0]  bi0, bi1;
  logic [3:0]  bi2;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_m8 (
    .clk(clk), .reset(reset),
    .i_load_valid(lv[0]), .i_load_data(ld0),
    .o_load_ready(lr[0]), .i_shift_en(se[0]),
    .o_serial_out(so[0]), .o_serial_valid(sv[0]),
    .o_serial_last(sl[0]), .o_bit_index(bi0)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_l8 (
    .clk(clk), .reset(reset),
    .i_load_valid(lv[1]), .i_load_data(ld1),
    .o_load_ready(lr[1]), .i_shift_en(se[1]),
    .o_serial_out(so[1]), .o_serial_valid(sv[1]),
    .o_serial_last(sl[1]), .o_bit_index(bi1)
  );

  piso_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) u_m16 (
    .clk(clk), .reset(reset),
    .i_load_valid(lv[2]), .i_load_data(ld2),
    .o_load_ready(lr[2]), .i_shift_en(se[2]),
    .o_serial_out(so[2]), .o_serial_valid(sv[2]),
    .o_serial_last(sl[2]), .o_bit_index(bi2)
  );

  int errors = 0;
  int checks = 0;

  bit          m_busy [3];
  logic [15:0] m_word [3];
  int          m_pos  [3];

  function automatic int wof(int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic bit lsbof(int i);
    return i == 1;
  endfunction

  function automatic logic [15:0] ldv(int i);
    case (i)
      0:       return {8'h00, ld0};
      1:       return {8'h00, ld1};
      default: return ld2;
    endcase
  endfunction

  function automatic logic [15:0] biv(int i);
    case (i)
      0:       return {13'h0, bi0};
      1:       return {13'h0, bi1};
      default: return {12'h0, bi2};
    endcase
  endfunction

  // Model: a frame is (word, position); the bit on the wire is simply
  // the word's bit at that position in the configured order.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_busy[i] <= 1'b0;
        m_pos[i]  <= 0;
        m_word[i] <= '0;
      end else if (!m_busy[i]) begin
        if (lv[i]) begin
          m_busy[i] <= 1'b1;
          m_word[i] <= ldv(i);
          m_pos[i]  <= 0;
        end
      end else if (se[i]) begin
        if (m_pos[i] < wof(i) - 1) begin
          m_pos[i] <= m_pos[i] + 1;
        end else begin
          m_pos[i] <= 0;
          if (lv[i]) m_word[i] <= ldv(i);
          else       m_busy[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic e_bit(int i);
    int idx;
    if (!m_busy[i]) return 1'b0;
    idx = lsbof(i) ? m_pos[i] : wof(i) - 1 - m_pos[i];
    return m_word[i][idx];
  endfunction

  function automatic logic e_last(int i);
    return m_busy[i] && (m_pos[i] == wof(i) - 1);
  endfunction

  task automatic check(input string nm, input int inst,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %0h want %0h",
               nm, inst, $time, act, exp);
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 3; i++) begin
      check("valid", i, 16'(sv[i]), 16'(m_busy[i]));
      check("last", i, 16'(sl[i]), 16'(e_last(i)));
      check("out", i, 16'(so[i]), 16'(e_bit(i)));
      check("index", i, biv(i),
            m_busy[i] ? 16'(m_pos[i]) : 16'h0);
      check("ready", i, 16'(lr[i]),
            16'(!m_busy[i] || (e_last(i) && se[i])));
    end
  endtask

  task automatic idle_lit(input int i);
    check("idle_out", i, 16'(so[i]), 16'h0);
    check("idle_valid", i, 16'(sv[i]), 16'h0);
    check("idle_last", i, 16'(sl[i]), 16'h0);
    check("idle_index", i, biv(i), 16'h0);
    check("idle_ready", i, 16'(lr[i]), 16'h1);
  endtask

  task automatic at_neg();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pm, pl, pb, ps, pa;
  int idx;

  initial begin
    lv = '0; se = '0;
    ld0 = '0; ld1 = '0; ld2 = '0;
    pm = 16'h00C1;
    pl = 16'h0083;
    pb = 16'hC15A;
    ps = 16'h00F0;
    pa = 16'hABCD;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp_all();
    for (int i = 0; i < 3; i++) idle_lit(i);
    @(posedge clk);
    #1 reset = 1'b0;

    // MSB-first and LSB-first, 0xC1, shift_en held
    se = 3'b011; lv = 3'b011;
    ld0 = 8'hC1; ld1 = 8'hC1;
    at_neg(); adv();
    lv = '0;
    for (int k = 0; k < 9; k++) begin
      at_neg();
      if (k < 8) begin
        check("msb_out", 0, 16'(so[0]), 16'(pm[7-k]));
        check("lsb_out", 1, 16'(so[1]), 16'(pl[7-k]));
        check("lsb_index", 1, biv(1), 16'(k));
      end
      check("msb_last", 0, 16'(sl[0]), 16'(k == 7));
      check("msb_valid", 0, 16'(sv[0]), 16'(k < 8));
      adv();
    end

    // Back-to-back 0xC1 then 0x5A
    se = 3'b001; lv = 3'b001; ld0 = 8'hC1;
    at_neg(); adv();
    ld0 = 8'h5A;
    for (int k = 0; k < 17; k++) begin
      at_neg();
      if (k < 16) begin
        check("b2b_out", 0, 16'(so[0]), 16'(pb[15-k]));
        check("b2b_valid", 0, 16'(sv[0]), 16'h1);
        check("b2b_ready", 0, 16'(lr[0]),
              16'(k == 7 || k == 15));
        check("b2b_last", 0, 16'(sl[0]),
              16'(k == 7 || k == 15));
      end else begin
        check("b2b_end", 0, 16'(sv[0]), 16'h0);
      end
      adv();
      if (k == 7) lv = 3'b000;
    end

    // Stall after bit 2 with a busy-time load attempt
    se = 3'b001; lv = 3'b001; ld0 = 8'hF0;
    at_neg(); adv();
    lv = '0; ld0 = 8'hFF;
    for (int c = 0; c < 12; c++) begin
      se[0] = !(c >= 2 && c <= 4);
      lv[0] = (c >= 2 && c <= 4);
      idx = (c < 2) ? c : (c < 5) ? 2 : c - 3;
      at_neg();
      if (c < 11) begin
        check("stall_out", 0, 16'(so[0]), 16'(ps[7-idx]));
        check("stall_index", 0, biv(0), 16'(idx));
        check("stall_valid", 0, 16'(sv[0]), 16'h1);
      end else begin
        check("stall_end", 0, 16'(sv[0]), 16'h0);
      end
      if (c >= 2 && c <= 4)
        check("stall_ready", 0, 16'(lr[0]), 16'h0);
      adv();
    end
    lv = '0; se = '0;

    // WIDTH=16: reset mid-frame, then 0x0001
    se = 3'b100; lv = 3'b100; ld2 = 16'hABCD;
    at_neg(); adv();
    lv = '0;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      check("w16_out", 2, 16'(so[2]), 16'(pa[15-k]));
      adv();
    end
    #2 reset = 1'b1;
    #1;
    idle_lit(2);
    cmp_all();
    #2 reset = 1'b0;
    adv();
    lv = 3'b100; ld2 = 16'h0001;
    at_neg(); adv();
    lv = '0;
    for (int k = 0; k < 17; k++) begin
      at_neg();
      if (k < 16) begin
        check("post_out", 2, 16'(so[2]), 16'(k == 15));
        check("post_index", 2, biv(2), 16'(k));
      end else begin
        check("post_end", 2, 16'(sv[2]), 16'h0);
      end
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load port, a stallable serial output and frame-boundary flagging. It replaces the fixed 4-bit shift register in serial transmit paths. It accepts a WIDTH-bit word from an upstream producer and emits it one bit per enabled cycle, MSB- or LSB-first. Back-to-back words stream with no idle bit between frames.

## Interface
- WIDTH, 8, word width in bits; legal range 2..64.
- LSB_FIRST, 0, bit order: 0 sends bit WIDTH-1 first, 1 sends bit 0 first.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  upstream has a word on load_data.
- load_data  input  WIDTH  parallel word; sampled only on an accepted load.
- load_ready  output  1  serializer can accept a word this cycle.
- shift_en  input  1  downstream consumes the presented bit this cycle; low = stall.
- serial_out  output  1  current bit; 0 when no frame is active.
- serial_valid  output  1  serial_out carries a frame bit.
- serial_last  output  1  the presented bit is the final bit of the frame.
- bit_index  output  $clog2(WIDTH)  index of the presented bit within the frame, 0 = first sent.

## Operation
- State: FSM {IDLE, SHIFT}, shift_reg[WIDTH-1:0], bit counter cnt[$clog2(WIDTH)-1:0].
- Load accept: an accept is load_valid && load_ready at a rising edge. On accept, shift_reg <= load_data, cnt <= 0, state <= SHIFT.
- load_ready is combinational. It is 1 in IDLE. It is also 1 in SHIFT when serial_last && shift_en, which is the final-bit consume cycle. It is 0 otherwise.
- While busy, load_valid is ignored and load_data is not sampled. The producer holds its word until load_ready is 1.
- Presented bit, MSB-first: serial_out = shift_reg[WIDTH-1]. On consume, shift_reg <= {shift_reg[WIDTH-2:0],1'b0}.
- Presented bit, LSB-first: serial_out = shift_reg[0]. On consume, shift_reg <= {1'b0,shift_reg[WIDTH-1:1]}.
- Consume: shift_en=1 in SHIFT.
  - If cnt < WIDTH-1: shift, cnt <= cnt+1.
  - If cnt == WIDTH-1 and load_valid=1: reload (back-to-back) — shift_reg <= load_data, cnt <= 0, stay in SHIFT.
  - If cnt == WIDTH-1 and load_valid=0: state <= IDLE, shift_reg <= 0, cnt <= 0.
- Stall: shift_en=0 in SHIFT holds shift_reg, cnt, state and all outputs.
- shift_en in IDLE has no effect.
- Outputs:
  - serial_valid = (state==SHIFT).
  - serial_last = serial_valid && cnt==WIDTH-1.
  - bit_index = cnt.
  - In IDLE, serial_out = 0 and bit_index = 0.
- Reset values: state IDLE, shift_reg 0, cnt 0. Resulting outputs: serial_out 0, serial_valid 0, serial_last 0, bit_index 0, load_ready 1.
- Reset mid-frame aborts the frame immediately. Remaining bits are discarded, with no partial-frame flag.

## Timing
- Load-to-first-bit latency: 1 cycle. If a word is accepted at edge N, its first bit is valid after edge N until the consume edge.
- Throughput: one bit per cycle with shift_en high. A frame occupies exactly WIDTH consume cycles.
- Back-to-back: with load_valid high during the last-bit cycle, the next frame's bit 0 follows the previous last bit with zero gap. serial_valid stays high continuously.
- With no pending word, serial_valid drops the cycle after the last-bit consume. A word arriving then is accepted from IDLE, giving a 1-cycle gap.
- load_ready depends combinationally on shift_en and cnt. The upstream must not make load_valid depend combinationally on load_ready.

## Test plan
- Reset check: assert reset mid-cycle, asynchronously -> outputs go immediately to serial_out 0, serial_valid 0, serial_last 0, bit_index 0, load_ready 1.
- MSB-first (WIDTH=8, LSB_FIRST=0): load 0xC1, shift_en held 1 -> serial_out 1,1,0,0,0,0,0,1 on 8 consecutive cycles. serial_last is high only on the 8th. serial_valid is 0 on the 9th.
- LSB-first (WIDTH=8, LSB_FIRST=1): load 0xC1 -> serial_out 1,0,0,0,0,0,1,1. bit_index runs 0..7.
- Back-to-back (WIDTH=8, MSB-first): load 0xC1, then hold load_valid with 0x5A. Expected:
  - load_ready pulses only in the last-bit cycle.
  - 16 contiguous valid bits: 11000001 01011010.
  - serial_last is high on bits 8 and 16.
- Stall and busy-ignore: load 0xF0, then drop shift_en for 3 cycles after bit 2. Expected:
  - serial_out, bit_index=2 and serial_valid are held during the stall.
  - load_valid with 0xFF during the stall is not accepted.
  - The frame completes as 1,1,1,1,0,0,0,0.
- Reset mid-frame (WIDTH=16): load 0xABCD, assert reset after bit 5 -> serial_valid 0 immediately. A post-reset load of 0x0001 outputs fifteen 0s then 1 from bit_index 0.
